// File: rtl/clk_divider_param_if.sv
// Control and status bundle for the parameterised clock divider.
// en/load/div_in come from the controlling side; q/tick/pending/div_active come from the divider.
interface clk_divider_param_if #(
    parameter int WIDTH = 8
);
    // load is a one-cycle strobe. There is no back-pressure: every sampled load is
    // accepted into the pending slot, and a later load overwrites an earlier one.
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_in;
    logic             q;
    logic             tick;
    logic             pending;
    logic [WIDTH-1:0] div_active;

    modport master (
        output en,
        output load,
        output div_in,
        input  q,
        input  tick,
        input  pending,
        input  div_active
    );

    modport slave (
        input  en,
        input  load,
        input  div_in,
        output q,
        output tick,
        output pending,
        output div_active
    );
endinterface

// File: rtl/clk_divider_param.sv
// Integer clock divider whose ratio can change at runtime. A new ratio is staged in a
// pending slot and takes effect only at a period boundary, so q never produces a runt phase.
module clk_divider_param #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input logic               clk,
    input logic               rst,
    clk_divider_param_if.slave bus
);
    localparam logic [WIDTH-1:0] DEF_RATIO = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_RATIO = WIDTH'(2);

    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] div_active, div_active_nx;
    logic [WIDTH-1:0] pend_ratio, pend_ratio_nx;
    logic             pend, pend_nx;
    logic             q, q_nx;
    logic             tick, tick_nx;
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] load_ratio;
    logic             boundary;

    // high = ceil(N/2): the odd leftover cycle goes to the high phase
    always_comb high = div_active - (div_active >> 1);

    always_comb load_ratio = (bus.div_in < MIN_RATIO) ? MIN_RATIO : bus.div_in;

    always_comb boundary = bus.en && (cnt == div_active - WIDTH'(1));

    always_comb begin
        cnt_nx        = cnt;
        q_nx          = q;
        tick_nx       = 1'b0;
        div_active_nx = div_active;
        pend_ratio_nx = pend_ratio;
        pend_nx       = pend;

        if (boundary) begin
            cnt_nx  = '0;
            q_nx    = 1'b1;
            tick_nx = 1'b1;
            if (pend) begin
                div_active_nx = pend_ratio;
            end
        end else if (bus.en) begin
            cnt_nx = cnt + WIDTH'(1);
            q_nx   = (cnt_nx < high);
        end

        // A load on the boundary edge is staged for the following boundary; whatever
        // was pending before the edge is what gets applied above.
        if (bus.load) begin
            pend_ratio_nx = load_ratio;
            pend_nx       = 1'b1;
        end else if (boundary && pend) begin
            pend_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= DEF_RATIO - WIDTH'(1);
            div_active <= DEF_RATIO;
            pend_ratio <= DEF_RATIO;
            pend       <= 1'b0;
            q          <= 1'b0;
            tick       <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            div_active <= div_active_nx;
            pend_ratio <= pend_ratio_nx;
            pend       <= pend_nx;
            q          <= q_nx;
            tick       <= tick_nx;
        end
    end

    assign bus.q          = q;
    assign bus.tick       = tick;
    assign bus.pending    = pend;
    assign bus.div_active = div_active;

    a_tick_single: assert property (@(posedge clk) disable iff (rst) tick |=> !tick);
    a_ratio_legal: assert property (@(posedge clk) disable iff (rst) div_active >= MIN_RATIO);

endmodule
